pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Instruction-cycle controller for the 6-bit core. Runs the fetch -> execute
//   -> PC-update sequence, holds the architectural PC, and requests instructions
//   over a req/ack handshake. Applies the branch unit's pcSel at the update step.
//   Supports a halt request that parks the core on an instruction boundary.
// PARAMETERS
//   PC_W      6   PC width; also the width of the ALU branch target
//   INSTR_W   8   instruction word width
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   clk          in   1        core clock, rising edge
//   reset        in   1        asynchronous, active-high; clears all state
//   fetch_req    out  1        instruction request; pc is valid while high
//   fetch_ack    in   1        memory has fetch_data valid this cycle
//   fetch_data   in   INSTR_W  instruction word from memory
//   instr        out  INSTR_W  latched current instruction for decode
//   instr_valid  out  1        1-cycle pulse: instr newly latched, execute starts
//   exec_done    in   1        datapath has finished the current instruction
//   pc_sel       in   1        from branch unit: 1 = PC+1, 0 = take alu_target
//   alu_target   in   PC_W     jump/branch target from ALU
//   halt         in   1        level; park at next instruction boundary
//   pc           out  PC_W     architectural program counter
//   halted       out  1        high while parked in HALT
//   pc_wrap      out  1        1-cycle pulse: sequential PC+1 wrapped max -> 0
// BEHAVIOUR
//   Reset (async, any state, mid-handshake included):
//     state = BOOT, pc = RESET_PC, instr = 0, and all outputs low
//     (fetch_req, instr_valid, halted, pc_wrap). Any in-flight fetch is abandoned.
//   States: BOOT, FETCH, EXEC, UPDATE, HALT. All outputs are registered or
//     decoded from state only; no input reaches an output combinationally.
//   BOOT:   stays 1 cycle after reset is released -> FETCH (or -> HALT if halt=1).
//   FETCH:  fetch_req = 1; pc is held stable.
//     fetch_ack = 0 -> stay in FETCH (no timeout).
//     fetch_ack = 1 -> instr <= fetch_data, go to EXEC.
//     fetch_ack is ignored in every other state.
//   EXEC:   instr_valid = 1 on the first EXEC cycle only.
//     exec_done = 1 -> UPDATE. exec_done = 1 on the same cycle as the
//     instr_valid pulse is legal and is accepted.
//     exec_done is ignored outside EXEC.
//   UPDATE: 1 cycle; pc_sel and alu_target are sampled here only.
//     pc_sel = 1 -> pc <= pc + 1, modulo 2^PC_W; pc_wrap pulses when pc was all-ones.
//     pc_sel = 0 -> pc <= alu_target; no wrap pulse.
//     Next state: HALT if halt = 1, else FETCH.
//   HALT:   halted = 1 and fetch_req = 0; pc is frozen.
//     halt = 0 -> FETCH on the next cycle.
//   Halt raised in FETCH or EXEC does not abort anything. The current
//     instruction completes and the PC updates before the core parks.
//   Minimum instruction time is 3 cycles (FETCH, EXEC, UPDATE), with ack and
//     done each returned in their first cycle.
//   instr holds its value through HALT until the next fetch_ack.
// TESTING
//   1. Reset, then hold fetch_ack=1, exec_done=1, pc_sel=1 ->
//      pc steps 0,1,2,... one step per 3 cycles; instr_valid pulses once per instruction.
//   2. Delay fetch_ack 4 cycles with fetch_data=8'hA5 -> fetch_req stays high
//      and pc is stable; instr=8'hA5 with instr_valid on the cycle after ack.
//   3. pc=6'h3F with pc_sel=1 at UPDATE -> pc=6'h00 and pc_wrap pulses for 1 cycle.
//      Repeat with pc_sel=0, alu_target=6'h15 -> pc=6'h15 and no wrap pulse.
//   4. Raise halt during EXEC of pc=5, pc_sel=1 -> the instruction completes,
//      pc=6, halted=1, fetch_req=0. Drop halt -> FETCH resumes at pc=6.
//   5. Assert reset during FETCH (pc=9) and again mid-EXEC -> outputs clear
//      asynchronously; after release the core spends 1 BOOT cycle, then fetches at pc=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller: BOOT -> FETCH -> EXEC -> UPDATE, with an
// instruction-boundary halt. Owns the architectural PC and the latched instruction.
module pc_sequencer #(
  parameter int              PC_W     = 6,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               fetch_req,
  input  logic               fetch_ack,
  input  logic [INSTR_W-1:0] fetch_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               pc_sel,
  input  logic [PC_W-1:0]    alu_target,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               pc_wrap,
  output logic [2:0]         dbg_state
);

  // Fetch handshake: fetch_req is high for the whole FETCH state and pc is
  // stable while it is; the word is taken on the first cycle fetch_ack is high.
  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               pc_wrap_q, pc_wrap_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_wrap_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_wrap_q     <= pc_wrap_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    pc_wrap_d     = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = halt ? S_HALT : S_FETCH;
      end
      S_FETCH: begin
        if (fetch_ack) begin
          instr_d       = fetch_data;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // pc_sel high means sequential; the wrap flag is registered so it
        // lines up with the cycle the new PC becomes visible.
        if (pc_sel) begin
          pc_d      = pc_q + 1'b1;
          pc_wrap_d = &pc_q;
        end else begin
          pc_d = alu_target;
        end
        state_d = halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!halt) state_d = S_FETCH;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign fetch_req   = (state_q == S_FETCH);
  assign halted      = (state_q == S_HALT);
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_wrap     = pc_wrap_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer; expected PC, wrap and
// instruction values come from an instruction-level model kept here.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       fetch_req;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic [7:0] instr;
  logic       instr_valid;
  logic       exec_done;
  logic       pc_sel;
  logic [5:0] alu_target;
  logic       halt;
  logic [5:0] pc;
  logic       halted;
  logic       pc_wrap;
  logic [2:0] dbg_state;

  int checks;
  int failures;
  int exp_pc;
  logic [7:0] exp_q[$];

  pc_sequencer #(.PC_W(6), .INSTR_W(8), .RESET_PC(6'd0)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .pc_sel(pc_sel), .alu_target(alu_target), .halt(halt),
    .pc(pc), .halted(halted), .pc_wrap(pc_wrap), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset applied between clock edges; optional halt during BOOT.
  task automatic async_reset(input logic boot_halt);
    #2 reset = 1'b1;
    #1;
    chk("rst_req", fetch_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wrap", pc_wrap, 0);
    fetch_ack = 1'b0;
    exec_done = 1'b0;
    halt      = boot_halt;
    @(negedge clk);
    reset  = 1'b0;
    exp_pc = 0;
    exp_q.delete();
    chk("boot_req", fetch_req, 0);
    @(negedge clk);
    if (boot_halt) begin
      chk("boot_halted", halted, 1);
      chk("boot_halt_req", fetch_req, 0);
      halt = 1'b0;
      @(negedge clk);
    end
    chk("boot_fetch_req", fetch_req, 1);
    chk("boot_fetch_pc", pc, exp_pc);
  endtask

  // One full instruction; entered and left on a negedge with the core in FETCH.
  task automatic run_instr(input int ack_dly, input logic [7:0] data, input int done_dly,
                           input logic sel, input logic [5:0] tgt,
                           input logic do_halt, input int halt_cyc);
    logic exp_wrap;
    int   nxt;
    chk("fetch_req", fetch_req, 1);
    chk("fetch_pc", pc, exp_pc);
    halt = do_halt && ($urandom_range(0, 1) == 1);
    repeat (ack_dly) begin
      fetch_ack  = 1'b0;
      fetch_data = 8'($urandom);
      @(negedge clk);
      chk("wait_req", fetch_req, 1);
      chk("wait_pc", pc, exp_pc);
    end
    fetch_ack  = 1'b1;
    fetch_data = data;
    exp_q.push_back(data);
    @(negedge clk);
    fetch_ack  = 1'b0;
    fetch_data = 8'($urandom);
    halt       = do_halt;
    chk("instr_valid", instr_valid, 1);
    chk("instr", instr, exp_q.pop_front());
    chk("exec_req", fetch_req, 0);
    chk("exec_wrap", pc_wrap, 0);
    exec_done  = 1'b0;
    pc_sel     = 1'($urandom);
    alu_target = 6'($urandom);
    repeat (done_dly) begin
      @(negedge clk);
      chk("valid_once", instr_valid, 0);
      chk("exec_pc", pc, exp_pc);
    end
    exec_done  = 1'b1;
    pc_sel     = sel;
    alu_target = tgt;
    @(negedge clk);
    exec_done = 1'b0;
    chk("upd_pc", pc, exp_pc);
    chk("upd_valid", instr_valid, 0);
    if (sel) begin
      nxt      = exp_pc + 1;
      exp_wrap = (nxt == 64);
      exp_pc   = nxt % 64;
    end else begin
      exp_wrap = 1'b0;
      exp_pc   = int'(tgt);
    end
    @(negedge clk);
    pc_sel     = 1'($urandom);
    alu_target = 6'($urandom);
    chk("next_pc", pc, exp_pc);
    chk("pc_wrap", pc_wrap, exp_wrap);
    chk("halted", halted, do_halt);
    chk("req_after", fetch_req, !do_halt);
    if (do_halt) begin
      repeat (halt_cyc) begin
        @(negedge clk);
        chk("halt_pc", pc, exp_pc);
        chk("halt_halted", halted, 1);
        chk("halt_req", fetch_req, 0);
        chk("halt_wrap", pc_wrap, 0);
      end
      halt = 1'b0;
      @(negedge clk);
      chk("resume_req", fetch_req, 1);
      chk("resume_halted", halted, 0);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_pc     = 0;
    reset      = 1'b1;
    fetch_ack  = 1'b0;
    fetch_data = '0;
    exec_done  = 1'b0;
    pc_sel     = 1'b0;
    alu_target = '0;
    halt       = 1'b0;
    @(negedge clk);
    async_reset(1'b0);

    // back-to-back sequential instructions, 3 cycles each
    repeat (4) run_instr(0, 8'($urandom), 0, 1'b1, 6'($urandom), 1'b0, 0);

    // slow memory: ack after 4 cycles with A5
    run_instr(4, 8'hA5, 1, 1'b1, 6'($urandom), 1'b0, 0);

    // wrap from 3F, then a jump from 3F with no wrap
    run_instr(0, 8'($urandom), 0, 1'b0, 6'h3F, 1'b0, 0);
    run_instr(0, 8'($urandom), 0, 1'b1, 6'($urandom), 1'b0, 0);
    run_instr(0, 8'($urandom), 0, 1'b0, 6'h3F, 1'b0, 0);
    run_instr(0, 8'($urandom), 0, 1'b0, 6'h15, 1'b0, 0);

    // halt raised during the instruction at pc 5
    run_instr(0, 8'($urandom), 0, 1'b0, 6'h05, 1'b0, 0);
    run_instr(1, 8'($urandom), 2, 1'b1, 6'($urandom), 1'b1, 3);
    run_instr(0, 8'($urandom), 0, 1'b1, 6'($urandom), 1'b0, 0);

    // async reset in FETCH at pc 9 with ack pending
    run_instr(0, 8'($urandom), 0, 1'b0, 6'h09, 1'b0, 0);
    chk("pre_rst_pc", pc, 9);
    fetch_ack  = 1'b1;
    fetch_data = 8'h3C;
    async_reset(1'b0);

    // async reset mid-EXEC
    fetch_ack  = 1'b1;
    fetch_data = 8'h5A;
    @(negedge clk);
    fetch_ack = 1'b0;
    chk("mid_exec_instr", instr, 8'h5A);
    @(negedge clk);
    async_reset(1'b0);

    // reset released with halt already high: BOOT goes straight to HALT
    async_reset(1'b1);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      run_instr($urandom_range(0, 3), 8'($urandom), $urandom_range(0, 3),
                1'($urandom_range(0, 3) != 0), 6'($urandom),
                1'($urandom_range(0, 5) == 0), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
